mac_accum: RTL
==============

MAC_ACCUM -- requirements
Module: mac_accum

Interface
REQ-001 SHALL have parameter N_TERMS, default 4, giving the number of products summed per result (1..15).
REQ-002 SHALL have parameter ACC_W, default 12, giving the signed accumulator width (10..16).
REQ-003 SHALL have input clk, 1 bit, the clock; all state changes on the rising edge.
REQ-004 SHALL have input rst, 1 bit, asynchronous active-high reset.
REQ-005 SHALL have input clr, 1 bit, a synchronous abort that starts a new accumulation.
REQ-006 SHALL have input prod_valid, 1 bit, meaning prod and prod_sub are valid (driven from the multiplier done).
REQ-007 SHALL have input prod, 8 bits, an unsigned product from the 4x4 multiplier.
REQ-008 SHALL have input prod_sub, 1 bit; 1 means subtract prod, 0 means add prod.
REQ-009 SHALL have output in_ready, 1 bit, meaning the block accepts a product this cycle.
REQ-010 SHALL have output acc_out, ACC_W bits, the signed two's-complement running sum.
REQ-011 SHALL have output out_valid, 1 bit, meaning acc_out holds a completed result.
REQ-012 SHALL have input out_ready, 1 bit, meaning the consumer takes the result.
REQ-013 SHALL have output term_cnt, 4 bits, the number of products accepted so far.
REQ-014 SHALL have output overflow, 1 bit, a sticky saturation flag.

Function
REQ-015 SHALL define an input transfer as prod_valid=1 and in_ready=1 at a rising edge; prod_valid while in_ready=0 SHALL be ignored.
REQ-016 SHALL implement the FSM states IDLE, ACC and DONE.
REQ-017 IDLE: in_ready=1, acc_out=0, term_cnt=0; a transfer SHALL load acc_out with +/-prod, set term_cnt=1 and go to ACC, or to DONE if N_TERMS=1.
REQ-018 ACC: in_ready=1; a transfer SHALL set acc_out to acc_out +/- prod and increment term_cnt; if term_cnt reaches N_TERMS the FSM SHALL go to DONE.
REQ-019 DONE: out_valid=1 and in_ready=0; out_ready=1 SHALL return the FSM to IDLE next cycle, clearing acc_out, term_cnt and overflow.
REQ-020 SHALL treat prod as zero-extended to ACC_W before add or subtract.
REQ-021 SHALL make acc_out registered; out_valid SHALL rise exactly one cycle after the N_TERMS-th transfer edge.
REQ-022 SHALL hold acc_out stable in DONE for as long as out_ready=0.
REQ-023 SHALL give clr=1 highest priority in any state: next state IDLE with acc_out=0, term_cnt=0 and overflow=0; any transfer in that same cycle is discarded.
REQ-024 Without the saturation feature, SHALL wrap arithmetic modulo 2^ACC_W.

Reset
REQ-025 rst=1 SHALL immediately force state IDLE, acc_out=0, term_cnt=0, overflow=0, out_valid=0 and in_ready=1, regardless of clk.
REQ-026 Reset in the middle of an accumulation SHALL discard all partial sums; the first transfer after release starts a fresh result.

Configuration
REQ-027 With MAC_ACCUM_SAT_EN defined, each update SHALL clamp to [-2^(ACC_W-1), 2^(ACC_W-1)-1] and set overflow when clamping occurs; overflow SHALL stay set until IDLE is re-entered.
REQ-028 Without MAC_ACCUM_SAT_EN, SHALL wrap per REQ-024 and tie overflow to 0.

Verification
REQ-029 Sum: N_TERMS=4, ACC_W=12, prods 4,9,16,36 all add, one per cycle -> out_valid one cycle after the 4th, acc_out=65, term_cnt=4.
REQ-030 Complex real part: N_TERMS=2, prod=2 add then prod=4 sub -> acc_out=-2 (0xFFE).
REQ-031 Backpressure: in DONE, hold out_ready=0 for 3 cycles while prod_valid=1 -> acc_out unchanged, in_ready=0, no products absorbed; out_ready=1 -> IDLE next cycle.
REQ-032 clr: after 2 of 4 terms assert clr with prod_valid=1 -> acc_out=0, term_cnt=0; the next 4 transfers produce a correct fresh sum.
REQ-033 Saturation: ACC_W=10, N_TERMS=3, three adds of 225 -> with MAC_ACCUM_SAT_EN acc_out=511 and overflow=1; without it acc_out=-349 and overflow=0.
REQ-034 Async reset: assert rst between clock edges during ACC -> outputs at reset values before the next edge.

Source files
------------

// File: rtl/mac_accum.sv
// Multiply-accumulate sequencer: sums N_TERMS signed +/- products into a registered result.
// Define MAC_ACCUM_SAT_EN to clamp each update and flag overflow; otherwise arithmetic wraps.
module mac_accum #(
  parameter int N_TERMS = 4,
  parameter int ACC_W   = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             prod_valid,
  input  logic [7:0]       prod,
  input  logic             prod_sub,
  output logic             in_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       term_cnt,
  output logic             overflow
);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t           state, state_n;
  logic [ACC_W-1:0] acc, acc_n, base, upd;
  logic [3:0]       cnt, cnt_n, cnt_inc;
  logic             ovf, ovf_n, upd_ovf;
  logic             take;
  logic [ACC_W-1:0] prod_ext;

  assign in_ready  = (state != DONE);
  assign out_valid = (state == DONE);
  assign acc_out   = acc;
  assign term_cnt  = cnt;
  assign overflow  = ovf;

  assign take     = prod_valid && in_ready;
  assign cnt_inc  = cnt + 4'd1;
  assign prod_ext = {{(ACC_W-8){1'b0}}, prod};
  // The first term of a result always starts from zero.
  assign base     = (state == IDLE) ? '0 : acc;

`ifdef MAC_ACCUM_SAT_EN
  logic [ACC_W:0] wide;
  always_comb begin
    wide    = prod_sub ? ({base[ACC_W-1], base} - {1'b0, prod_ext})
                       : ({base[ACC_W-1], base} + {1'b0, prod_ext});
    upd     = wide[ACC_W-1:0];
    upd_ovf = 1'b0;
    // Extra sign bit disagreeing with the result MSB means the true sum left range.
    if (wide[ACC_W] != wide[ACC_W-1]) begin
      upd_ovf = 1'b1;
      upd     = wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end
`else
  always_comb begin
    upd     = prod_sub ? (base - prod_ext) : (base + prod_ext);
    upd_ovf = 1'b0;
  end
`endif

  always_comb begin
    state_n = state;
    acc_n   = acc;
    cnt_n   = cnt;
    ovf_n   = ovf;
    if (clr) begin
      state_n = IDLE;
      acc_n   = '0;
      cnt_n   = '0;
      ovf_n   = 1'b0;
    end else begin
      case (state)
        IDLE: if (take) begin
          acc_n   = upd;
          cnt_n   = 4'd1;
          ovf_n   = upd_ovf;
          state_n = (N_TERMS == 1) ? DONE : ACC;
        end
        ACC: if (take) begin
          acc_n = upd;
          cnt_n = cnt_inc;
          ovf_n = ovf | upd_ovf;
          if (cnt_inc == 4'(N_TERMS)) state_n = DONE;
        end
        DONE: if (out_ready) begin
          state_n = IDLE;
          acc_n   = '0;
          cnt_n   = '0;
          ovf_n   = 1'b0;
        end
        default: begin
          state_n = IDLE;
          acc_n   = '0;
          cnt_n   = '0;
          ovf_n   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_n;
      acc   <= acc_n;
      cnt   <= cnt_n;
      ovf   <= ovf_n;
    end
  end

endmodule
